// File: rtl/arbiter_wrr_lock.sv
// Weighted round-robin arbiter with packet lock: a winner keeps the grant for up to
// weight[i] complete transactions, then priority rotates past it.
module arbiter_wrr_lock #(
  parameter  int REQ_WIDTH    = 4,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int ID_WIDTH     = $clog2(REQ_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REQ_WIDTH-1:0]              req,
  input  logic [REQ_WIDTH-1:0]              last,
  input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
  input  logic                              ready,
  output logic [REQ_WIDTH-1:0]              gnt,
  output logic [ID_WIDTH-1:0]               gnt_id,
  output logic                              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                  state, state_n;
  logic [REQ_WIDTH-1:0]                    gnt_n;
  logic [ID_WIDTH-1:0]                     gnt_id_n, base, base_n, pick;
  logic [WEIGHT_WIDTH-1:0]                 credit, credit_n, pick_w;
  logic                                    in_pkt, in_pkt_n, accept;
  logic [REQ_WIDTH-1:0][WEIGHT_WIDTH-1:0]  wts;

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_wts
    assign wts[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Scan downward in distance from base so the nearest requester wins last.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int k = REQ_WIDTH-1; k >= 0; k--) begin
      idx = (int'(base) + k) % REQ_WIDTH;
      if (req[idx]) pick = ID_WIDTH'(idx);
    end
  end

  assign pick_w = wts[pick];
  assign accept = (state == GRANT) && req[gnt_id] && ready;
  assign busy   = (state == GRANT);

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    credit_n = credit;
    in_pkt_n = in_pkt;
    base_n   = base;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n     = GRANT;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          gnt_id_n    = pick;
          credit_n    = (pick_w == '0) ? WEIGHT_WIDTH'(1) : pick_w;
          in_pkt_n    = 1'b0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (last[gnt_id]) begin
            in_pkt_n = 1'b0;
            credit_n = credit - 1'b1;
            if (credit == WEIGHT_WIDTH'(1)) state_n = IDLE;
          end else begin
            in_pkt_n = 1'b1;
          end
        end else if (!req[gnt_id] && !in_pkt) begin
          state_n = IDLE;
        end
        // Release: drop grant and hand priority to the port after the winner.
        if (state_n == IDLE) begin
          gnt_n    = '0;
          gnt_id_n = '0;
          base_n   = (gnt_id == ID_WIDTH'(REQ_WIDTH-1)) ? '0 : gnt_id + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      credit <= '0;
      in_pkt <= 1'b0;
      base   <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      gnt_id <= gnt_id_n;
      credit <= credit_n;
      in_pkt <= in_pkt_n;
      base   <= base_n;
    end
  end

endmodule

// File: tb/tb_arbiter_wrr_lock.sv
// Scoreboard bench: a transaction-level arbiter model predicts each cycle's grant,
// a monitor compares the DUT one step after every rising edge.
module tb_arbiter_wrr_lock;
  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*WW-1:0] weight = '0;
  logic            ready = 1'b0;
  logic [N-1:0]    gnt;
  logic [1:0]      gnt_id;
  logic            busy;

  arbiter_wrr_lock #(.REQ_WIDTH(N), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight),
    .ready(ready), .gnt(gnt), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    int           id;
    int           b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the resource, how many transactions it may still
  // finish, whether it is mid-packet, and which port is first in line next.
  int owner = -1;
  int left  = 0;
  int nextp = 0;
  bit mid   = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int wt(input int i);
    return int'(weight[i*WW +: WW]);
  endfunction

  task automatic model_step();
    exp_t e;
    bit   rel;
    int   i;
    rel = 1'b0;
    if (rst) begin
      owner = -1; left = 0; nextp = 0; mid = 1'b0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (nextp + k) % N;
        if (req[i] && owner < 0) begin
          owner = i;
          left  = (wt(i) == 0) ? 1 : wt(i);
          mid   = 1'b0;
        end
      end
    end else begin
      if (req[owner] && ready) begin
        if (last[owner]) begin
          mid  = 1'b0;
          left = left - 1;
          rel  = (left == 0);
        end else begin
          mid = 1'b1;
        end
      end else if (!req[owner] && !mid) begin
        rel = 1'b1;
      end
      if (rel) begin
        nextp = (owner + 1) % N;
        owner = -1;
      end
    end
    e.g = '0;
    if (owner >= 0) e.g[owner] = 1'b1;
    e.id = (owner >= 0) ? owner : 0;
    e.b  = (owner >= 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(gnt_id), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("onehot", int'($countones(gnt) <= 1), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_gnt", int'(gnt), int'(e.g));
        chk("sb_id", int'(gnt_id), e.id);
        chk("sb_busy", int'(busy), e.b);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seq1[9];
    int seq2[5];
    int bsy2[5];
    int t3_req[7];
    int t3_rdy[7];
    int t3_lst[7];
    int t3_exp[7];
    seq1   = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    seq2   = '{4, 4, 4, 0, 4};
    bsy2   = '{1, 1, 1, 0, 1};
    t3_req = '{1, 1, 1, 0, 0, 1, 1};
    t3_rdy = '{1, 0, 1, 1, 0, 1, 1};
    t3_lst = '{0, 0, 0, 0, 0, 0, 1};
    t3_exp = '{1, 1, 1, 1, 1, 1, 0};
    #2;
    do_reset();

    // Equal weights, everyone requesting: plain rotation with an idle gap.
    weight = {N{4'd1}}; req = 4'b1111; last = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t1_rotate", int'(gnt), seq1[i]);
    end

    // Weight 3 on a lone requester: three beats, one idle cycle, regrant.
    do_reset();
    weight = 16'h0300; req = 4'b0100; last = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_gnt", int'(gnt), seq2[i]);
      chk("t2_busy", int'(busy), bsy2[i]);
    end

    // Multi-beat packet with stalls and a dropped request: lock until last beat.
    do_reset();
    weight = 16'h1111; req = 4'b0001; last = 4'b0000; ready = 1'b1;
    tick();
    chk("t3_grant", int'(gnt), 1);
    for (int i = 0; i < 7; i++) begin
      req   = t3_req[i] ? 4'b0001 : 4'b0000;
      ready = t3_rdy[i][0];
      last  = t3_lst[i] ? 4'b0001 : 4'b0000;
      tick();
      chk("t3_lock", int'(gnt), t3_exp[i]);
    end
    req = 4'b0000;
    tick();
    chk("t3_idle", int'(gnt), 0);

    // Early release with unused credit, then rotation skips past the winner.
    do_reset();
    weight = 16'h0020; req = 4'b0010; last = 4'b1111; ready = 1'b1;
    tick();
    chk("t4_grant", int'(gnt), 2);
    tick();
    chk("t4_hold", int'(gnt), 2);
    req = 4'b0000;
    tick();
    chk("t4_release", int'(gnt), 0);
    req = 4'b1001;
    tick();
    chk("t4_next", int'(gnt), 8);
    chk("t4_next_id", int'(gnt_id), 3);

    // Zero weight behaves as one transaction.
    do_reset();
    weight = 16'h0000; req = 4'b0001; last = 4'b1111; ready = 1'b1;
    tick();
    chk("t5_grant", int'(gnt), 1);
    tick();
    chk("t5_release", int'(gnt), 0);
    tick();
    chk("t5_regrant", int'(gnt), 1);

    // Reset in the middle of a packet.
    do_reset();
    weight = 16'h0300; req = 4'b0100; last = 4'b0000; ready = 1'b1;
    tick();
    chk("t6_grant", int'(gnt), 4);
    tick();
    chk("t6_inpkt", int'(gnt), 4);
    req = 4'b1111;
    do_reset();
    tick();
    chk("t6_after_rst", int'(gnt), 1);

    // Randomized traffic against the model.
    do_reset();
    weight = 16'h2131;
    for (int c = 0; c < 600; c++) begin
      req   = 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      last  = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
